sync_fifo_param: RTL and testbench

//   Parametrised single-clock FIFO: configurable data width and depth, occupancy count,

---
 rtl/sync_fifo_param_if.sv | 31 +++
 rtl/sync_fifo_param.sv | 105 ++++++++++
 tb/tb_sync_fifo_param.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_param_if.sv
// Handshake/data bundle for sync_fifo_param: producer/consumer side is master,
// the FIFO is slave.
interface sync_fifo_param_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             flush;
  logic             wr_en;
  logic [WIDTH-1:0] data_in;
  logic             rd_en;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output flush, wr_en, data_in, rd_en,
    input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, data_in, rd_en,
    output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost flags, flush and
// sticky overflow/underflow. Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_param #(
  parameter int WIDTH         = 32,
  parameter int DEPTH         = 1024,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic             clock,
  input  logic             resetn,
  sync_fifo_param_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    rd_nxt;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             full_w, empty_w, rd_acc, wr_acc;

  assign full_w  = (count_q == CW'(DEPTH));
  assign empty_w = (count_q == '0);
  assign rd_nxt  = rd_ptr_q + AW'(1);

  // A full FIFO still takes a write when the same edge frees a slot.
  assign rd_acc = bus.rd_en && !empty_w;
  assign wr_acc = bus.wr_en && (!full_w || rd_acc);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      dout_d   = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_acc) rd_ptr_d = rd_nxt;
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (bus.wr_en && !wr_acc) ovf_d = 1'b1;
      if (bus.rd_en && empty_w) udf_d = 1'b1;
`ifdef SYNC_FIFO_FWFT_EN
      // dout_q mirrors the head slot; on a pop it loads the following word,
      // or the incoming word when the pop would otherwise leave it empty.
      if (rd_acc) begin
        if (count_q > CW'(1))  dout_d = mem_q[rd_nxt];
        else if (wr_acc)       dout_d = bus.data_in;
      end else if (wr_acc && empty_w) begin
        dout_d = bus.data_in;
      end
`else
      if (rd_acc) dout_d = mem_q[rd_ptr_q];
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is not reset; only pointers/count define what is valid.
  always_ff @(posedge clock) begin
    if (resetn && !bus.flush && wr_acc) mem_q[wr_ptr_q] <= bus.data_in;
  end

  assign bus.data_out     = dout_q;
  assign bus.count        = count_q;
  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (count_q >= CW'(AFULL_THRESH));
  assign bus.almost_empty = (count_q <= CW'(AEMPTY_THRESH));
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param at DEPTH=8, WIDTH=32, AFULL=6, AEMPTY=2.
module tb_sync_fifo_param;
  localparam int W  = 32;
  localparam int D  = 8;
  localparam int AF = 6;
  localparam int AE = 2;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  sync_fifo_param_if #(.WIDTH(W), .DEPTH(D)) bus ();

  sync_fifo_param #(.WIDTH(W), .DEPTH(D), .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  int         n_chk  = 0;
  int         n_fail = 0;
  logic [W-1:0] sb [$];
  logic [W-1:0] exp_w;

  // inputs change 1 time unit after the rising edge; outputs are sampled there too
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.flush = 1'b0; bus.data_in = '0;
  endtask

  task automatic do_reset();
    resetn = 1'b0; idle(); step(); resetn = 1'b1; sb.delete();
  endtask

  task automatic test_reset();
    resetn = 1'b0; idle(); step(); step();
    n_chk++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b exp 1", bus.empty); end
    n_chk++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b exp 0", bus.full); end
    n_chk++; if (bus.almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_aempty got %b exp 1", bus.almost_empty); end
    n_chk++; if (bus.almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_afull got %b exp 0", bus.almost_full); end
    n_chk++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", bus.count); end
    n_chk++; if (bus.data_out !== 32'h0) begin n_fail++; $display("FAIL reset_dout got %h exp 0", bus.data_out); end
    n_chk++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
      n_fail++; $display("FAIL reset_sticky got ovf=%b udf=%b exp 0/0", bus.overflow, bus.underflow); end
    resetn = 1'b1; sb.delete();
  endtask

  task automatic test_fill();
    for (int i = 1; i <= D; i++) begin
      bus.wr_en = 1'b1; bus.data_in = W'(i); sb.push_back(W'(i));
      step();
      n_chk++; if (bus.count !== 4'(i)) begin n_fail++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, bus.count, i); end
      n_chk++; if (bus.almost_empty !== (i <= AE)) begin n_fail++; $display("FAIL fill_aempty[%0d] got %b exp %b", i, bus.almost_empty, (i <= AE)); end
      n_chk++; if (bus.almost_full !== (i >= AF)) begin n_fail++; $display("FAIL fill_afull[%0d] got %b exp %b", i, bus.almost_full, (i >= AF)); end
      n_chk++; if (bus.full !== (i == D) || bus.empty !== 1'b0) begin
        n_fail++; $display("FAIL fill_full_empty[%0d] got full=%b empty=%b exp %b/0", i, bus.full, bus.empty, (i == D)); end
    end
    bus.data_in = 32'h9;
    step(); idle();
    n_chk++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b exp 1", bus.overflow); end
    n_chk++; if (bus.count !== 4'd8 || bus.full !== 1'b1) begin
      n_fail++; $display("FAIL ovf_count got %0d full=%b exp 8/1", bus.count, bus.full); end
  endtask

`ifndef SYNC_FIFO_FWFT_EN
  task automatic test_drain();
    for (int i = 0; i < D; i++) begin
      bus.rd_en = 1'b1;
      step();
      exp_w = sb.pop_front();
      n_chk++; if (bus.data_out !== exp_w) begin n_fail++; $display("FAIL drain_dout[%0d] got %h exp %h", i, bus.data_out, exp_w); end
      n_chk++; if (bus.count !== 4'(D - 1 - i)) begin n_fail++; $display("FAIL drain_count[%0d] got %0d exp %0d", i, bus.count, D - 1 - i); end
    end
    step(); idle();
    n_chk++; if (bus.underflow !== 1'b1) begin n_fail++; $display("FAIL udf_set got %b exp 1", bus.underflow); end
    n_chk++; if (bus.data_out !== 32'h8 || bus.empty !== 1'b1) begin
      n_fail++; $display("FAIL udf_hold got dout=%h empty=%b exp 8/1", bus.data_out, bus.empty); end
    n_chk++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b exp 1", bus.overflow); end
  endtask

  task automatic test_simul_full();
    do_reset();
    for (int i = 1; i <= D; i++) begin
      bus.wr_en = 1'b1; bus.data_in = W'(i); sb.push_back(W'(i)); step();
    end
    bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.data_in = 32'hA;
    step(); idle();
    exp_w = sb.pop_front(); sb.push_back(32'hA);
    n_chk++; if (bus.data_out !== exp_w) begin n_fail++; $display("FAIL simul_dout got %h exp %h", bus.data_out, exp_w); end
    n_chk++; if (bus.count !== 4'd8 || bus.overflow !== 1'b0) begin
      n_fail++; $display("FAIL simul_state got count=%0d ovf=%b exp 8/0", bus.count, bus.overflow); end
    for (int i = 0; i < D; i++) begin
      bus.rd_en = 1'b1; step();
      exp_w = sb.pop_front();
      n_chk++; if (bus.data_out !== exp_w) begin n_fail++; $display("FAIL wrap_dout[%0d] got %h exp %h", i, bus.data_out, exp_w); end
    end
    idle();
  endtask
`endif

  task automatic test_flush();
    do_reset();
    bus.rd_en = 1'b1; step(); idle();
    n_chk++; if (bus.underflow !== 1'b1) begin n_fail++; $display("FAIL flush_pre_udf got %b exp 1", bus.underflow); end
    for (int i = 0; i < 6; i++) begin
      bus.wr_en = 1'b1; bus.data_in = 32'h10 + W'(i); step();
    end
    bus.wr_en = 1'b0; bus.rd_en = 1'b1; step(); idle();
    n_chk++; if (bus.count !== 4'd5) begin n_fail++; $display("FAIL flush_pre_count got %0d exp 5", bus.count); end
    bus.flush = 1'b1; bus.wr_en = 1'b1; bus.data_in = 32'h77;
    step(); idle();
    n_chk++; if (bus.count !== 4'd0 || bus.empty !== 1'b1) begin
      n_fail++; $display("FAIL flush_count got %0d empty=%b exp 0/1", bus.count, bus.empty); end
    n_chk++; if (bus.data_out !== 32'h0) begin n_fail++; $display("FAIL flush_dout got %h exp 0", bus.data_out); end
    n_chk++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
      n_fail++; $display("FAIL flush_sticky got ovf=%b udf=%b exp 0/0", bus.overflow, bus.underflow); end
    step();
    n_chk++; if (bus.count !== 4'd0) begin n_fail++; $display("FAIL flush_wr_ignored got %0d exp 0", bus.count); end
  endtask

`ifdef SYNC_FIFO_FWFT_EN
  task automatic test_fwft();
    do_reset();
    bus.wr_en = 1'b1; bus.data_in = 32'h55; step(); idle();
    n_chk++; if (bus.empty !== 1'b0 || bus.data_out !== 32'h55) begin
      n_fail++; $display("FAIL fwft_visible got empty=%b dout=%h exp 0/55", bus.empty, bus.data_out); end
    n_chk++; if (bus.count !== 4'd1) begin n_fail++; $display("FAIL fwft_count got %0d exp 1", bus.count); end
    bus.rd_en = 1'b1; step(); idle();
    n_chk++; if (bus.empty !== 1'b1 || bus.count !== 4'd0) begin
      n_fail++; $display("FAIL fwft_pop got empty=%b count=%0d exp 1/0", bus.empty, bus.count); end
    for (int i = 0; i < 3; i++) begin
      bus.wr_en = 1'b1; bus.data_in = 32'hC0 + W'(i); sb.push_back(32'hC0 + W'(i)); step();
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      exp_w = sb.pop_front();
      n_chk++; if (bus.data_out !== exp_w) begin n_fail++; $display("FAIL fwft_head[%0d] got %h exp %h", i, bus.data_out, exp_w); end
      bus.rd_en = 1'b1; step(); idle();
    end
  endtask
`endif

  task automatic test_back_to_back();
    bit w, r, rd_ok, wr_ok;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      if (i < 100)      begin w = ($urandom_range(0, 3) != 0); r = ($urandom_range(0, 3) == 0); end
      else if (i < 200) begin w = ($urandom_range(0, 3) == 0); r = ($urandom_range(0, 3) != 0); end
      else              begin w = $urandom_range(0, 1) != 0;   r = $urandom_range(0, 1) != 0;   end
      rd_ok = r && (sb.size() > 0);
      wr_ok = w && (sb.size() < D || rd_ok);
      bus.wr_en = w; bus.rd_en = r; bus.data_in = $urandom;
      if (wr_ok) sb.push_back(bus.data_in);
      if (rd_ok) exp_w = sb.pop_front();
      step();
      n_chk++; if (bus.count !== 4'(sb.size())) begin n_fail++; $display("FAIL b2b_count[%0d] got %0d exp %0d", i, bus.count, sb.size()); end
      n_chk++; if (bus.full !== (sb.size() == D) || bus.empty !== (sb.size() == 0)) begin
        n_fail++; $display("FAIL b2b_flags[%0d] got full=%b empty=%b exp size %0d", i, bus.full, bus.empty, sb.size()); end
`ifdef SYNC_FIFO_FWFT_EN
      if (sb.size() > 0) begin
        n_chk++; if (bus.data_out !== sb[0]) begin n_fail++; $display("FAIL b2b_head[%0d] got %h exp %h", i, bus.data_out, sb[0]); end
      end
`else
      if (rd_ok) begin
        n_chk++; if (bus.data_out !== exp_w) begin n_fail++; $display("FAIL b2b_dout[%0d] got %h exp %h", i, bus.data_out, exp_w); end
      end
`endif
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_fill();
`ifndef SYNC_FIFO_FWFT_EN
    test_drain();
    test_simul_full();
`endif
    test_flush();
`ifdef SYNC_FIFO_FWFT_EN
    test_fwft();
`endif
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
